gate_test_sequencer: RTL and testbench

Self-checking controller that exhaustively drives an N-input combinational gate under test through all 2^N input vectors. It waits a programmable settle time per vector, samples the gate output and compares it against a truth table latched at start. It reports pass/fail, the mismatch count and the first failing vector. It sits beside the lab gate modules as the synthesizable replacement for hand-toggled testbench clocks.

---
 rtl/gate_test_sequencer.sv | 175 +++++++++++++++++
 tb/tb_gate_test_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/gate_test_sequencer.sv
// gate_test_sequencer
//   Walks an N-input combinational gate under test through every input
//   vector 0 .. 2^N-1. Each vector is held for SETTLE_CYCLES clocks, then
//   gate_out is sampled once and compared against a truth table that was
//   captured when the run started. The result is reported as a pass flag,
//   a mismatch count and the first vector that mismatched.
//
// Ports
//   clock            : system clock, rising edge
//   reset_n          : asynchronous active-low reset
//   start            : begin a run (only honoured while idle)
//   expected         : truth table, bit k = required gate_out for vector k
//   gate_out         : output of the gate under test
//   gate_in          : registered vector driven into the gate under test
//   busy             : run in progress (start acceptance up to FINISH)
//   done             : one-cycle pulse when the run finishes
//   pass             : last completed run had no mismatches
//   fail_count       : mismatches in the current or last run
//   first_fail_vec   : first vector that mismatched
//   first_fail_valid : first_fail_vec is meaningful
module gate_test_sequencer #(
  parameter int N_INPUTS      = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [2**N_INPUTS-1:0]   expected,
  input  logic                     gate_out,
  output logic [N_INPUTS-1:0]      gate_in,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [N_INPUTS:0]        fail_count,
  output logic [N_INPUTS-1:0]      first_fail_vec,
  output logic                     first_fail_valid
);

  localparam int NV = 2**N_INPUTS;
  // The settle counter only has to reach SETTLE_CYCLES-1; keep at least one bit.
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  localparam logic [SW-1:0]       SETTLE_RELOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0]       SETTLE_ONE    = SW'(1);
  localparam logic [N_INPUTS-1:0] VEC_ONE       = N_INPUTS'(1);
  localparam logic [N_INPUTS-1:0] VEC_MAX       = N_INPUTS'(NV - 1);
  localparam logic [N_INPUTS:0]   FC_ONE        = (N_INPUTS + 1)'(1);

  logic [1:0]          state_q, state_d;
  logic [NV-1:0]       exp_q, exp_d;
  logic [N_INPUTS-1:0] vec_q, vec_d;
  logic [SW-1:0]       settle_q, settle_d;
  logic [N_INPUTS-1:0] gate_in_q, gate_in_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [N_INPUTS:0]   fc_q, fc_d;
  logic [N_INPUTS-1:0] ffvec_q, ffvec_d;
  logic                ffvalid_q, ffvalid_d;

  logic                mismatch;
  logic [N_INPUTS:0]   fc_sampled;

  // Next-state logic. done defaults low so it only pulses on the single
  // transition into FINISH. pass is decided from the count that already
  // includes the final sample, so the last vector is never missed.
  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    vec_d      = vec_q;
    settle_d   = settle_q;
    gate_in_d  = gate_in_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    fc_d       = fc_q;
    ffvec_d    = ffvec_q;
    ffvalid_d  = ffvalid_q;
    mismatch   = (gate_out != exp_q[vec_q]);
    fc_sampled = mismatch ? (fc_q + FC_ONE) : fc_q;

    case (state_q)
      ST_IDLE: begin
        gate_in_d = '0;
        busy_d    = 1'b0;
        if (start) begin
          exp_d     = expected;
          vec_d     = '0;
          gate_in_d = '0;
          settle_d  = SETTLE_RELOAD;
          fc_d      = '0;
          ffvalid_d = 1'b0;
          pass_d    = 1'b0;
          busy_d    = 1'b1;
          state_d   = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_q == '0) begin
          state_d = ST_SAMPLE;
        end else begin
          settle_d = settle_q - SETTLE_ONE;
        end
      end
      ST_SAMPLE: begin
        fc_d = fc_sampled;
        if (mismatch && !ffvalid_q) begin
          ffvec_d   = vec_q;
          ffvalid_d = 1'b1;
        end
        if (vec_q == VEC_MAX) begin
          state_d = ST_FINISH;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (fc_sampled == '0);
        end else begin
          vec_d     = vec_q + VEC_ONE;
          gate_in_d = vec_q + VEC_ONE;
          settle_d  = SETTLE_RELOAD;
          state_d   = ST_SETTLE;
        end
      end
      ST_FINISH: begin
        gate_in_d = '0;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any run immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      exp_q     <= '0;
      vec_q     <= '0;
      settle_q  <= '0;
      gate_in_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fc_q      <= '0;
      ffvec_q   <= '0;
      ffvalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      vec_q     <= vec_d;
      settle_q  <= settle_d;
      gate_in_q <= gate_in_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      fc_q      <= fc_d;
      ffvec_q   <= ffvec_d;
      ffvalid_q <= ffvalid_d;
    end
  end

  assign gate_in          = gate_in_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign fail_count       = fc_q;
  assign first_fail_vec   = ffvec_q;
  assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// tb_gate_test_sequencer
//   Drives two sequencers (2-input / settle 2 and 3-input / settle 1), each
//   wired to a behavioural gate model, and compares cycle-by-cycle activity
//   and run results against expectations derived from the truth table.
module tb_gate_test_sequencer;

  logic       clock = 1'b0;
  logic       resetN;

  logic       startA, startB;
  logic [3:0] expectedA;
  logic [7:0] expectedB;
  logic       gateOutA, gateOutB;
  logic [1:0] gateInA;
  logic [2:0] gateInB;
  logic       busyA, busyB, doneA, doneB, passA, passB;
  logic [2:0] failCountA;
  logic [3:0] failCountB;
  logic [1:0] ffVecA;
  logic [2:0] ffVecB;
  logic       ffValidA, ffValidB;

  int         modeVar;
  logic [7:0] hiddenTable;
  bit         selB;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clock = ~clock;

  gate_test_sequencer #(.N_INPUTS(2), .SETTLE_CYCLES(2)) dutA (
    .clock(clock), .reset_n(resetN), .start(startA), .expected(expectedA),
    .gate_out(gateOutA), .gate_in(gateInA), .busy(busyA), .done(doneA),
    .pass(passA), .fail_count(failCountA), .first_fail_vec(ffVecA),
    .first_fail_valid(ffValidA)
  );

  gate_test_sequencer #(.N_INPUTS(3), .SETTLE_CYCLES(1)) dutB (
    .clock(clock), .reset_n(resetN), .start(startB), .expected(expectedB),
    .gate_out(gateOutB), .gate_in(gateInB), .busy(busyB), .done(doneB),
    .pass(passB), .fail_count(failCountB), .first_fail_vec(ffVecB),
    .first_fail_valid(ffValidB)
  );

  // Behavioural gate: 0 AND, 1 OR, 2 XOR, 3 stuck-at-0, else hidden table.
  function automatic logic gateFn(input int mode, input int v, input int n,
                                  input logic [7:0] tbl);
    case (mode)
      0:       return (v == (1 << n) - 1);
      1:       return (v != 0);
      2:       return logic'($countones(v) % 2);
      3:       return 1'b0;
      default: return tbl[v];
    endcase
  endfunction

  assign gateOutA = gateFn(modeVar, int'(gateInA), 2, hiddenTable);
  assign gateOutB = gateFn(modeVar, int'(gateInB), 3, hiddenTable);

  logic [2:0] obsGateIn, obsFfVec;
  logic [3:0] obsFailCount;
  logic       obsBusy, obsDone, obsPass, obsFfValid;
  assign obsGateIn    = selB ? gateInB    : {1'b0, gateInA};
  assign obsFfVec     = selB ? ffVecB     : {1'b0, ffVecA};
  assign obsFailCount = selB ? failCountB : {1'b0, failCountA};
  assign obsBusy      = selB ? busyB      : busyA;
  assign obsDone      = selB ? doneB      : doneA;
  assign obsPass      = selB ? passB      : passA;
  assign obsFfValid   = selB ? ffValidB   : ffValidA;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expectedVal);
    checkCount++;
    if (observed !== expectedVal) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expectedVal);
    end
  endtask

  task automatic applyStimulus(input bit useB, input logic startVal,
                               input logic [7:0] expVal);
    if (useB) begin
      startB    = startVal;
      expectedB = expVal;
    end else begin
      startA    = startVal;
      expectedA = expVal[3:0];
    end
  endtask

  // One complete run. disturb=1 pokes start mid-run and in FINISH and
  // changes the truth table after acceptance; none of it may matter.
  task automatic runTest(input bit useB, input int mode, input logic [7:0] expIn,
                         input bit disturb);
    int n, s, nv, total, cnt, first;
    n     = useB ? 3 : 2;
    s     = useB ? 1 : 2;
    nv    = 1 << n;
    total = nv * (s + 1);
    cnt   = 0;
    first = -1;
    for (int k = 0; k < nv; k++) begin
      if (gateFn(mode, k, n, hiddenTable) != expIn[k]) begin
        cnt++;
        if (first < 0) first = k;
      end
    end

    @(negedge clock);
    selB    = useB;
    modeVar = mode;
    applyStimulus(useB, 1'b1, expIn);
    @(posedge clock);
    for (int j = 0; j < total; j++) begin
      @(negedge clock);
      if (j == 0) applyStimulus(useB, 1'b0, expIn);
      if (disturb && j == 2) applyStimulus(useB, 1'b1, expIn);
      if (disturb && j == 3) applyStimulus(useB, 1'b0, expIn);
      if (disturb && j == 4) applyStimulus(useB, 1'b0, 8'h00);
      checkOutput("gate_in_step", 32'(obsGateIn), 32'(j / (s + 1)));
      checkOutput("busy_in_run", 32'(obsBusy), 32'd1);
      checkOutput("done_early", 32'(obsDone), 32'd0);
      @(posedge clock);
    end
    @(negedge clock);
    checkOutput("done_pulse", 32'(obsDone), 32'd1);
    checkOutput("busy_finish", 32'(obsBusy), 32'd0);
    checkOutput("pass", 32'(obsPass), 32'(cnt == 0));
    checkOutput("fail_count", 32'(obsFailCount), 32'(cnt));
    checkOutput("ff_valid", 32'(obsFfValid), 32'(cnt != 0));
    if (cnt != 0) checkOutput("ff_vec", 32'(obsFfVec), 32'(first));
    if (disturb) applyStimulus(useB, 1'b1, 8'h00);
    @(posedge clock);
    @(negedge clock);
    checkOutput("done_cleared", 32'(obsDone), 32'd0);
    checkOutput("busy_idle", 32'(obsBusy), 32'd0);
    checkOutput("gate_in_idle", 32'(obsGateIn), 32'd0);
    checkOutput("pass_held", 32'(obsPass), 32'(cnt == 0));
    applyStimulus(useB, 1'b0, expIn);
  endtask

  task automatic checkResetA(input string tag);
    checkOutput({tag, "_gate_in"}, 32'(gateInA), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busyA), 32'd0);
    checkOutput({tag, "_done"}, 32'(doneA), 32'd0);
    checkOutput({tag, "_pass"}, 32'(passA), 32'd0);
    checkOutput({tag, "_fail_count"}, 32'(failCountA), 32'd0);
    checkOutput({tag, "_ff_vec"}, 32'(ffVecA), 32'd0);
    checkOutput({tag, "_ff_valid"}, 32'(ffValidA), 32'd0);
  endtask

  initial begin
    resetN      = 1'b0;
    startA      = 1'b0;
    startB      = 1'b0;
    expectedA   = '0;
    expectedB   = '0;
    modeVar     = 0;
    hiddenTable = '0;
    selB        = 1'b0;
    #12;
    checkResetA("reset");
    checkOutput("reset_busyB", 32'(busyB), 32'd0);
    @(negedge clock);
    resetN = 1'b1;

    runTest(0, 0, 8'b1000, 0);       // AND, passes
    runTest(0, 1, 8'b1000, 0);       // OR, fails at 1 and 2
    runTest(0, 0, 8'b1000, 1);       // ignored restarts / table change

    // Asynchronous reset in the middle of a run.
    @(negedge clock);
    selB    = 1'b0;
    modeVar = 0;
    applyStimulus(0, 1'b1, 8'b1000);
    @(negedge clock);
    applyStimulus(0, 1'b0, 8'b1000);
    for (int i = 0; i < 20 && gateInA != 2'd2; i++) @(negedge clock);
    checkOutput("reach_vec2", 32'(gateInA), 32'd2);
    #2;
    resetN = 1'b0;
    #1;
    checkResetA("async_reset");
    @(negedge clock);
    resetN = 1'b1;
    runTest(0, 0, 8'b1000, 0);

    runTest(1, 2, 8'b10010110, 0);   // XOR3 on the 3-input sequencer
    runTest(0, 3, 8'b1111, 0);       // stuck-at-0, maximum count
    runTest(0, 0, 8'b1000, 0);       // count clears, passes again

    for (int r = 0; r < 10; r++) begin
      hiddenTable = 8'($urandom);
      runTest(bit'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
              8'($urandom), bit'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
